// File: rtl/adder_pkg.sv
// Shared constants and types for the adder operand generator.
// Defines the LFSR taps, the zero-seed substitute and the generator FSM state encoding.
package adder_pkg;

   localparam int          ADDER_W       = 8;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } gen_state_t;

   // An all-zero seed would lock the LFSR, so it is swapped for a fixed non-zero value.
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_ZERO_SUB : s;
   endfunction

endpackage

// File: rtl/adder_operand_gen_lfsr16_step.sv
// One step of the 16-bit Galois LFSR (right shift, x^16+x^14+x^13+x^11+1).
// Purely combinational so the same next-state function can be reused outside the generator.
module lfsr16_step
   import adder_pkg::*;
(
   input  logic [15:0] cur,
   output logic [15:0] nxt
);

   // Shift right and fold the tap mask back in when the bit leaving the register is set.
   always_comb begin
      if (cur[0]) begin
         nxt = {1'b0, cur[15:1]} ^ LFSR_TAPS;
      end else begin
         nxt = {1'b0, cur[15:1]};
      end
   end

endmodule

// File: rtl/adder_operand_gen.sv
// Flow-controlled pseudo-random operand source for the 8-bit adder.
// Issues num_pairs operand pairs from a seeded LFSR, each with its golden {cout,sum}.
module adder_operand_gen
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      seed,
   input  logic [CNT_W-1:0] num_pairs,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   exp,
   output logic             valid,
   input  logic             ready,
   output logic [CNT_W-1:0] pair_idx,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   gen_state_t       state_r;
   logic [15:0]      lfsr_r;
   logic [15:0]      lfsr_nxt_s;
   logic [CNT_W-1:0] n_r;
   logic [CNT_W-1:0] pair_idx_r;
   logic             valid_r;
   logic             busy_r;
   logic             done_r;
   logic             accept_s;
   logic             last_pair_s;

   lfsr16_step u_step (
      .cur (lfsr_r),
      .nxt (lfsr_nxt_s)
   );

   assign accept_s    = valid_r & ready;
   assign last_pair_s = (pair_idx_r == (n_r - CNT_ONE));

   // Sequencer: latches the run parameters, walks the LFSR on each accept and owns all output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         lfsr_r     <= 16'h0000;
         n_r        <= CNT_ZERO;
         pair_idx_r <= CNT_ZERO;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  lfsr_r  <= seed_fix(seed);
                  n_r     <= num_pairs;
                  busy_r  <= 1'b1;
                  state_r <= LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               pair_idx_r <= CNT_ZERO;
               if (n_r == CNT_ZERO) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  valid_r <= 1'b1;
                  state_r <= RUN;
               end
            end
            RUN: begin
               if (accept_s) begin
                  // The last pair stays on a/b/pair_idx so DONE still shows what was issued.
                  if (last_pair_s) begin
                     valid_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     lfsr_r     <= lfsr_nxt_s;
                     pair_idx_r <= pair_idx_r + CNT_ONE;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign a        = lfsr_r[15:8];
   assign b        = lfsr_r[7:0];
   assign exp      = {1'b0, a} + {1'b0, b};
   assign valid    = valid_r;
   assign pair_idx = pair_idx_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_adder_operand_gen.sv
// Self-checking bench for adder_operand_gen: table-driven runs, hand-written corner
// sequences, and a scoreboard that pops one expected pair per valid&ready handshake.
module tb_adder_operand_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] seed;
   logic [7:0]  num_pairs;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [8:0]  exp;
   logic        valid;
   logic        ready;
   logic [7:0]  pair_idx;
   logic        busy;
   logic        done;

   int n_vec  = 0;
   int n_err  = 0;
   int hs_cnt = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] sum;
      logic [7:0] idx;
   } pair_t;

   typedef struct packed {
      logic [15:0]     seed;
      logic [7:0]      n;
      logic [2:0][7:0] ea;
      logic [2:0][7:0] eb;
      logic [2:0][8:0] ee;
   } run_vec_t;

   pair_t    sb_q[$];
   pair_t    mon_e;
   run_vec_t vecs[4];

   adder_operand_gen #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .seed      (seed),
      .num_pairs (num_pairs),
      .a         (a),
      .b         (b),
      .exp       (exp),
      .valid     (valid),
      .ready     (ready),
      .pair_idx  (pair_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] m_step(input logic [15:0] x);
      logic [15:0] t;
      t = {1'b0, x[15:1]};
      if (x[0]) t = t ^ 16'hB400;
      return t;
   endfunction

   task automatic push_model(input logic [15:0] s, input int n);
      logic [15:0] x;
      pair_t p;
      x = (s == 16'h0000) ? 16'hACE1 : s;
      for (int i = 0; i < n; i++) begin
         p.a   = x[15:8];
         p.b   = x[7:0];
         p.sum = {1'b0, x[15:8]} + {1'b0, x[7:0]};
         p.idx = 8'(i);
         sb_q.push_back(p);
         x = m_step(x);
      end
   endtask

   function automatic run_vec_t mk(input logic [15:0] s, input logic [7:0] n,
                                   input logic [7:0] a0, input logic [7:0] b0, input logic [8:0] e0,
                                   input logic [7:0] a1, input logic [7:0] b1, input logic [8:0] e1,
                                   input logic [7:0] a2, input logic [7:0] b2, input logic [8:0] e2);
      run_vec_t v;
      v.seed = s;  v.n = n;
      v.ea[0] = a0; v.eb[0] = b0; v.ee[0] = e0;
      v.ea[1] = a1; v.eb[1] = b1; v.ee[1] = e1;
      v.ea[2] = a2; v.eb[2] = b2; v.ee[2] = e2;
      return v;
   endfunction

   task automatic start_run(input logic [15:0] s, input logic [7:0] n);
      @(posedge clk); #1;
      seed = s; num_pairs = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; seed = 16'($urandom); num_pairs = 8'($urandom);
   endtask

   task automatic wait_done(input int budget, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < budget);
      check("done_seen", 32'(done), 32'd1);
   endtask

   // Scoreboard monitor: golden sum on every valid cycle, pair match on every handshake.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         check("exp_eq_a_plus_b", 32'(exp), 32'({1'b0, a} + {1'b0, b}));
         check("done_while_valid", 32'(done), 32'd0);
         if (ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pair: got a=%0h b=%0h idx=%0d, required no handshake", a, b, pair_idx);
            end else begin
               mon_e = sb_q.pop_front();
               check("pair_a",   32'(a),        32'(mon_e.a));
               check("pair_b",   32'(b),        32'(mon_e.b));
               check("pair_exp", 32'(exp),      32'(mon_e.sum));
               check("pair_idx", 32'(pair_idx), 32'(mon_e.idx));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int busy_cnt;
      int valid_cnt;
      int done_k;
      bit seen;

      rst_n = 1'b0; start = 1'b0; ready = 1'b0; seed = 16'h0000; num_pairs = 8'd0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_a", 32'(a), 32'd0);
      check("rst_b", 32'(b), 32'd0);
      check("rst_exp", 32'(exp), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_pair_idx", 32'(pair_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      #2 rst_n = 1'b1;

      // Table-driven runs with ready tied high
      vecs[0] = mk(16'h0000, 8'd3, 8'hAC, 8'hE1, 9'h18D, 8'hE2, 8'h70, 9'h152, 8'h71, 8'h38, 9'h0A9);
      vecs[1] = mk(16'h000F, 8'd3, 8'h00, 8'h0F, 9'h00F, 8'hB4, 8'h07, 9'h0BB, 8'hEE, 8'h03, 9'h0F1);
      vecs[2] = mk(16'hFFFF, 8'd2, 8'hFF, 8'hFF, 9'h1FE, 8'hCB, 8'hFF, 9'h1CA, 8'h00, 8'h00, 9'h000);
      vecs[3] = mk(16'hACE1, 8'd1, 8'hAC, 8'hE1, 9'h18D, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 9'h000);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pair_t p;
         for (int j = 0; j < int'(vecs[i].n); j++) begin
            p.a = vecs[i].ea[j]; p.b = vecs[i].eb[j]; p.sum = vecs[i].ee[j]; p.idx = 8'(j);
            sb_q.push_back(p);
         end
         start_run(vecs[i].seed, vecs[i].n);
         wait_done(20, k);
         check("tbl_done_latency", 32'(k), 32'(vecs[i].n) + 32'd2);
         check("tbl_done_valid", 32'(valid), 32'd0);
         check("tbl_done_busy", 32'(busy), 32'd0);
         check("tbl_last_a", 32'(a), 32'(vecs[i].ea[vecs[i].n - 8'd1]));
         check("tbl_last_b", 32'(b), 32'(vecs[i].eb[vecs[i].n - 8'd1]));
         check("tbl_last_idx", 32'(pair_idx), 32'(vecs[i].n - 8'd1));
         check("tbl_sb_empty", 32'(sb_q.size()), 32'd0);
         @(negedge clk);
         check("tbl_done_one_cycle", 32'(done), 32'd0);
      end

      // Back-pressure: first pair held while ready is low, then a start during DONE is ignored
      ready = 1'b0;
      push_model(16'h000F, 2);
      start_run(16'h000F, 8'd2);
      @(negedge clk);
      check("bp_busy_load", 32'(busy), 32'd1);
      check("bp_valid_load", 32'(valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid_hold", 32'(valid), 32'd1);
         check("bp_a_hold", 32'(a), 32'h00);
         check("bp_b_hold", 32'(b), 32'h0F);
         check("bp_exp_hold", 32'(exp), 32'h00F);
         check("bp_idx_hold", 32'(pair_idx), 32'd0);
      end
      @(posedge clk); #1 ready = 1'b1;
      wait_done(20, k);
      check("bp_done_latency", 32'(k), 32'd3);
      seed = 16'h1111; num_pairs = 8'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("done_start_ignored_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_start_ignored_busy2", 32'(busy), 32'd0);
      check("done_start_ignored_a", 32'(a), 32'hB4);
      check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

      // Empty run
      busy_cnt = 0; valid_cnt = 0; done_k = 0;
      start_run(16'h1234, 8'd0);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         busy_cnt += int'(busy);
         valid_cnt += int'(valid);
         if (done) done_k = j;
      end
      check("empty_done_at", 32'(done_k), 32'd2);
      check("empty_busy_cycles", 32'(busy_cnt), 32'd1);
      check("empty_valid_cycles", 32'(valid_cnt), 32'd0);

      // Start re-asserted during RUN with other parameters
      hs_cnt = 0;
      push_model(16'h1234, 5);
      start_run(16'h1234, 8'd5);
      @(posedge clk); #1 start = 1'b1; seed = 16'hBEEF; num_pairs = 8'd9;
      @(posedge clk); #1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(20, k);
      check("ign_handshakes", 32'(hs_cnt), 32'd5);
      check("ign_last_idx", 32'(pair_idx), 32'd4);
      check("ign_sb_empty", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
      check("ign_idle_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-run, then replay from the same seed
      push_model(16'h5A5A, 10);
      start_run(16'h5A5A, 8'd10);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_a", 32'(a), 32'd0);
      check("mid_rst_b", 32'(b), 32'd0);
      check("mid_rst_exp", 32'(exp), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_idx", 32'(pair_idx), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      check("mid_rst_no_done", 32'(done), 32'd0);
      #2 rst_n = 1'b1;
      hs_cnt = 0;
      push_model(16'h5A5A, 10);
      start_run(16'h5A5A, 8'd10);
      wait_done(30, k);
      check("replay_latency", 32'(k), 32'd12);
      check("replay_handshakes", 32'(hs_cnt), 32'd10);
      check("replay_sb_empty", 32'(sb_q.size()), 32'd0);

      // Long run with random ready
      hs_cnt = 0; seen = 1'b0; ready = 1'b0;
      push_model(16'hC0DE, 255);
      start_run(16'hC0DE, 8'd255);
      for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
         @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("long_done_seen", 32'(seen), 32'd1);
      check("long_handshakes", 32'(hs_cnt), 32'd255);
      check("long_last_idx", 32'(pair_idx), 32'd254);
      check("long_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
